// File: rtl/uart_word_sender_if.sv
// Host/transmitter signal bundle for uart_word_sender.
// The slave modport is the sequencer; the master modport drives the host and UART sides.
interface uart_word_sender_if;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  logic [WORD_W-1:0] word_in;
  logic              send;
  logic              TX_BUSY;
  logic [BYTE_W-1:0] Tx_DATA;
  logic              Tx_WR;
  logic              TX_EN;
  logic              ready;
  logic              busy;
  logic              done;
  logic              tx_error;

  modport master (
    output word_in, send, TX_BUSY,
    input  Tx_DATA, Tx_WR, TX_EN, ready, busy, done, tx_error
  );

  modport slave (
    input  word_in, send, TX_BUSY,
    output Tx_DATA, Tx_WR, TX_EN, ready, busy, done, tx_error
  );
endinterface

// File: rtl/uart_word_sender.sv
// Splits a 16-bit word into two UART byte writes (high byte first), paced by the
// transmitter busy flag, with a one-word pending buffer and a sticky ack-timeout flag.
module uart_word_sender #(
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  uart_word_sender_if.slave bus
);
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned TMO_W       = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned GAP_W       = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  // The low byte returns through IDLE, which costs one cycle of the gap.
  localparam int unsigned GAP_LAST_HI = GAP_CYCLES;
  localparam int unsigned GAP_LAST_LO = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] buf_q;
  logic [WORD_W-1:0] active_q, active_nxt;
  logic              valid_q, valid_nxt;
  logic              sel_lo_q, sel_lo_nxt;
  logic [TMO_W-1:0]  tmo_q, tmo_nxt;
  logic [GAP_W-1:0]  gap_q, gap_nxt;
  logic [GAP_W-1:0]  gap_last_c;
  logic              accept_c, pop_c, timeout_c, done_c;

  logic [BYTE_W-1:0] data_q, data_nxt;
  logic              wr_q, en_q, ready_q, busy_q, done_q, err_q, err_nxt;

  assign accept_c   = bus.send && ready_q;
  assign gap_last_c = sel_lo_q ? GAP_W'(GAP_LAST_LO) : GAP_W'(GAP_LAST_HI);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      buf_q    <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      sel_lo_q <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      en_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      active_q <= active_nxt;
      valid_q  <= valid_nxt;
      sel_lo_q <= sel_lo_nxt;
      tmo_q    <= tmo_nxt;
      gap_q    <= gap_nxt;
      if (accept_c) buf_q <= bus.word_in;
      data_q   <= data_nxt;
      wr_q     <= (state_nxt == S_WRITE);
      en_q     <= 1'b1;
      ready_q  <= !valid_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= done_c;
      err_q    <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    active_nxt = active_q;
    sel_lo_nxt = sel_lo_q;
    tmo_nxt    = tmo_q;
    gap_nxt    = gap_q;
    pop_c      = 1'b0;
    timeout_c  = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_q && !bus.TX_BUSY) begin
          pop_c      = 1'b1;
          active_nxt = buf_q;
          sel_lo_nxt = 1'b0;
          state_nxt  = S_WRITE;
        end
      end
      S_WRITE: begin
        tmo_nxt   = '0;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.TX_BUSY) begin
          state_nxt = S_WAIT_DONE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
          if (tmo_nxt == TMO_W'(BUSY_TIMEOUT)) begin
            timeout_c = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!bus.TX_BUSY) begin
          gap_nxt   = '0;
          done_c    = sel_lo_q;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == gap_last_c) begin
          if (!sel_lo_q) begin
            sel_lo_nxt = 1'b1;
            state_nxt  = S_WRITE;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gap_nxt = gap_q + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer, error flag and transmit byte updates
  always_comb begin
    valid_nxt = valid_q;
    err_nxt   = err_q;
    data_nxt  = data_q;
    if (pop_c)     valid_nxt = 1'b0;
    if (accept_c) begin
      valid_nxt = 1'b1;
      err_nxt   = 1'b0;
    end
    if (timeout_c) err_nxt = 1'b1;
    if (state_nxt == S_WRITE)
      data_nxt = sel_lo_nxt ? active_nxt[BYTE_W-1:0] : active_nxt[WORD_W-1:BYTE_W];
  end

  assign bus.Tx_DATA  = data_q;
  assign bus.Tx_WR    = wr_q;
  assign bus.TX_EN    = en_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_error = err_q;
endmodule
